// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CALC   = 2'b01,
        S_FINISH = 2'b10
    } state_e;

    localparam int MD_ITER = 32;
    localparam int CNT_W   = 6;

endpackage

// File: rtl/muldiv_if.sv
// Request/response and HI/LO move bundle between the core and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Core side: issues requests and moves, observes status and HI/LO.
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One shift-add or restoring-divide step per cycle; signs are stripped at
// start and reapplied in the FINISH cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_ITER - 1);

    // Two's-complement magnitude when the value is to be treated as negative.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    state_e           state_reg, state_next;
    op_e              op_reg;
    logic [31:0]      a_mag_reg;
    logic [31:0]      b_mag_reg;
    logic             sign_a_reg;
    logic             sign_b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [63:0]      acc_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic             done_reg;

    logic             in_signed, in_div, in_sign_a, in_sign_b;
    logic [31:0]      in_a_mag, in_b_mag;
    logic             op_is_div;
    logic [32:0]      add_sum;
    logic [32:0]      rem_shift;
    logic [31:0]      rem_diff;
    logic [63:0]      acc_step;
    logic [63:0]      prod_fix;
    logic [31:0]      fin_hi, fin_lo;

    assign bus.busy = (state_reg != S_IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

    assign op_is_div = (op_reg == MD_DIV) || (op_reg == MD_DIVU);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // FSM next-state: a fixed 32-iteration CALC phase bracketed by IDLE and FINISH.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (bus.start) state_next = S_CALC;
            S_CALC:   if (cnt_reg == LAST_ITER) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Operand conditioning at request time: strip signs for the signed ops.
    always_comb begin
        in_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        in_div    = (bus.op == MD_DIV)  || (bus.op == MD_DIVU);
        in_sign_a = in_signed & bus.a[31];
        in_sign_b = in_signed & bus.b[31];
        in_a_mag  = mag32(bus.a, in_sign_a);
        in_b_mag  = mag32(bus.b, in_sign_b);
    end

    // One iteration: shift-add multiply (LSB first) or restoring divide step.
    always_comb begin
        add_sum   = {1'b0, acc_reg[63:32]} + {1'b0, a_mag_reg};
        rem_shift = acc_reg[63:31];
        rem_diff  = rem_shift[31:0] - b_mag_reg;
        acc_step  = acc_reg;
        if (op_is_div) begin
            if (rem_shift >= {1'b0, b_mag_reg})
                acc_step = {rem_diff, acc_reg[30:0], 1'b1};
            else
                acc_step = {acc_reg[62:0], 1'b0};
        end else begin
            if (acc_reg[0])
                acc_step = {add_sum, acc_reg[31:1]};
            else
                acc_step = {1'b0, acc_reg[63:1]};
        end
    end

    // Sign fix-up and divide-by-zero override applied in the FINISH cycle.
    always_comb begin
        prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 64'd1) : acc_reg;
        fin_hi   = prod_fix[63:32];
        fin_lo   = prod_fix[31:0];
        if (op_is_div) begin
            if (b_mag_reg == 32'd0) begin
                // HI returns the dividend exactly as it arrived.
                fin_lo = 32'hFFFF_FFFF;
                fin_hi = mag32(a_mag_reg, sign_a_reg);
            end else begin
                fin_lo = mag32(acc_reg[31:0], sign_a_reg ^ sign_b_reg);
                fin_hi = mag32(acc_reg[63:32], sign_a_reg);
            end
        end
    end

    // Datapath, HI/LO ownership and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg     <= MD_MULT;
            a_mag_reg  <= '0;
            b_mag_reg  <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        // A request in the same cycle as a move wins; the move is dropped.
                        op_reg     <= bus.op;
                        a_mag_reg  <= in_a_mag;
                        b_mag_reg  <= in_b_mag;
                        sign_a_reg <= in_sign_a;
                        sign_b_reg <= in_sign_b;
                        cnt_reg    <= '0;
                        acc_reg    <= in_div ? {32'd0, in_a_mag} : {32'd0, in_b_mag};
                    end else begin
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                S_CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                S_FINISH: begin
                    hi_reg   <= fin_hi;
                    lo_reg   <= fin_lo;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, ignored inputs
// while busy, HI/LO moves and reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    muldiv_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request; cycles = edges from the start edge to the edge after which done is seen (-1 on timeout).
    task automatic run_op(input op_e o, input logic [31:0] x, input logic [31:0] y,
                          input bit with_move, output int cycles);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        if (with_move) begin
            bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_5555;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h0;
        cycles = 0;
        while (!bus.done && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.done) cycles = -1;
        $display("op=%s a=%h b=%h -> hi=%h lo=%h cycles=%0d", o.name(), x, y, bus.hi, bus.lo, cycles);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL reset_hi got=%h exp=0", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h0) $display("FAIL reset_lo got=%h exp=0", bus.lo); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int c;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, c);
        total_cnt++; if (c !== 33) $display("FAIL mult_latency got=%0d exp=33", c); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg_lo got=%h exp=ffffffeb", bus.lo); else pass_cnt++;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== 64'd21) $display("FAIL mult_negneg got=%h%h exp=%h", bus.hi, bus.lo, 64'd21); else pass_cnt++;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, c);
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got=%h exp=00000001", bus.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int c;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, c);
        total_cnt++; if (c !== 33) $display("FAIL div_latency got=%0d exp=33", c); else pass_cnt++;
        total_cnt++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); else pass_cnt++;
        run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'd1, 32'hFFFF_FFFD}) $display("FAIL div_negdivisor got=%h_%h exp=00000001_fffffffd", bus.hi, bus.lo); else pass_cnt++;
        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'd1, 32'd3}) $display("FAIL divu got=%h_%h exp=00000001_00000003", bus.hi, bus.lo); else pass_cnt++;
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'h0, 32'h8000_0000}) $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", bus.hi, bus.lo); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int c;
        run_op(MD_DIVU, 32'd5, 32'd0, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'd5, 32'hFFFF_FFFF}) $display("FAIL divu_zero got=%h_%h exp=00000005_ffffffff", bus.hi, bus.lo); else pass_cnt++;
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0, c);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) $display("FAIL div_zero got=%h_%h exp=fffffff0_ffffffff", bus.hi, bus.lo); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c;
        run_op(MD_MULTU, 32'd6, 32'd7, 1'b0, c);
        total_cnt++; if (bus.lo !== 32'd42) $display("FAIL b2b_first got=%h exp=0000002a", bus.lo); else pass_cnt++;
        // run_op re-issues start on the next negedge, still inside the done cycle.
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, c);
        total_cnt++; if (c !== 33) $display("FAIL b2b_latency got=%0d exp=33", c); else pass_cnt++;
        total_cnt++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) $display("FAIL b2b_second got=%h_%h exp=00000002_0000000e", bus.hi, bus.lo); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int done_seen = 0;
        int done_at = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL busy_set got=%b exp=1", bus.busy); else pass_cnt++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.lo_we = 1'b0;
        total_cnt++; if (bus.lo !== 32'd14) $display("FAIL busy_lo_hold got=%h exp=0000000e", bus.lo); else pass_cnt++;
        for (int i = 5; i <= 45; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                done_seen++;
                if (done_at < 0) begin
                    done_at = i;
                    total_cnt++; if ({bus.hi, bus.lo} !== {32'd0, 32'd15}) $display("FAIL busy_result got=%h_%h exp=00000000_0000000f", bus.hi, bus.lo); else pass_cnt++;
                end
            end
        end
        $display("busy test: done pulses=%0d first at edge %0d", done_seen, done_at);
        total_cnt++; if (done_seen !== 1) $display("FAIL busy_done_count got=%0d exp=1", done_seen); else pass_cnt++;
        total_cnt++; if (done_at !== 33) $display("FAIL busy_done_edge got=%0d exp=33", done_at); else pass_cnt++;
    endtask

    task automatic test_moves();
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
        total_cnt++; if (bus.lo !== 32'h1234) $display("FAIL mtlo got=%h exp=00001234", bus.lo); else pass_cnt++;
        total_cnt++; if (bus.hi !== 32'h0) $display("FAIL mtlo_hi_hold got=%h exp=00000000", bus.hi); else pass_cnt++;
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        $display("move: hi=%h lo=%h", bus.hi, bus.lo);
        total_cnt++; if ({bus.hi, bus.lo} !== {32'hA5A5_0F0F, 32'hA5A5_0F0F}) $display("FAIL mthi_mtlo got=%h_%h exp=a5a50f0f_a5a50f0f", bus.hi, bus.lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int c;
        int stray = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); else pass_cnt++;
        total_cnt++; if ({bus.hi, bus.lo} !== 64'h0) $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) stray++;
        end
        total_cnt++; if (stray !== 0) $display("FAIL rst_mid_no_done got=%0d exp=0", stray); else pass_cnt++;
        // Fresh request issued together with moves: the request wins.
        run_op(MD_DIVU, 32'd7, 32'd2, 1'b1, c);
        total_cnt++; if (c !== 33) $display("FAIL rst_fresh_latency got=%0d exp=33", c); else pass_cnt++;
        total_cnt++; if ({bus.hi, bus.lo} !== {32'd1, 32'd3}) $display("FAIL rst_fresh_result got=%h_%h exp=00000001_00000003", bus.hi, bus.lo); else pass_cnt++;
    endtask

    initial begin
        bus.start = 1'b0; bus.op = MD_MULT; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_busy_ignore();
        test_moves();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
